// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer chain and debounce filter
// producing a clean level plus registered single-cycle edge pulses.
module input_conditioner #(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_DEPTH    = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] INIT          = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  localparam int CW_RAW = $clog2(FILTER_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_DEPTH];
  logic [WIDTH-1:0] s;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic             any_d;

  assign s = sync_q[SYNC_DEPTH-1];

  // Synchronizer chain: plain flop-to-flop shift, never gated by en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < SYNC_DEPTH; j++) begin
        sync_q[j] <= INIT;
      end
    end else begin
      sync_q[0] <= in;
      for (int j = 1; j < SYNC_DEPTH; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  // Filter next state: any agreement clears the count, so a bounce
  // restarts the full stability window.
  always_comb begin
    out_d  = out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == out[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          out_d[i]  = s[i];
          cnt_d[i]  = '0;
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Filter registers: level, counters and pulses, all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out      <= INIT;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out      <= out_d;
      rise     <= rise_d;
      fall     <= fall_d;
      any_edge <= any_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule
